// File: rtl/viterbi_pkg.sv
// Shared types and width constants for the Viterbi decoder and its observation feeder.
package viterbi_pkg;

    localparam int DEF_N  = 8;
    localparam int DEF_K  = 3;
    localparam int SYM_W  = $clog2(DEF_K);
    localparam int LEN_W  = $clog2(DEF_N);
    localparam int IDX_W  = LEN_W;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_CAPTURE   = 2'd0,
        ST_PLAY_V    = 2'd1,
        ST_PLAY_G    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/obs_frame_buf.sv
// One-frame symbol store: synchronous write port, combinational read port.
module obs_frame_buf
    import viterbi_pkg::*;
#(
    parameter int DEPTH = DEF_N - 1,
    parameter int W     = SYM_W,
    parameter int AW    = IDX_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && int'(waddr) < DEPTH) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/viterbi_obs_feeder.sv
// Frames a valid/ready symbol stream and replays it to viterbi_top at one symbol per two cycles.
// Define VITERBI_FEEDER_STATS_EN to add the frames_sent / frames_dropped counters.
module viterbi_obs_feeder
    import viterbi_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [$clog2(K)-1:0]  s_sym,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  start,
    output logic [$clog2(N)-1:0]  length,
    output logic [$clog2(K)-1:0]  obs_in,
    output logic                  obs_valid,
    input  logic                  dec_done,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  frame_trunc,
`ifdef VITERBI_FEEDER_STATS_EN
    output logic [STAT_W-1:0]     frames_sent,
    output logic [STAT_W-1:0]     frames_dropped,
`endif
    output logic [1:0]            fsm_state
);

    localparam int SW = $clog2(K);
    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] LAST_CNT = LW'(N - 2);

    feeder_state_t state, state_n;
    logic [LW-1:0] cnt, cnt_n, idx, idx_n, length_n;
    logic          bad, bad_n, err_n, trunc_n, we, play_n, sym_bad, accept;
    logic [SW-1:0] rd_data, sym_n;
    logic [LW-1:0] rd_addr;

    assign accept    = s_valid & s_ready;
    assign sym_bad   = int'(s_sym) >= K;
    assign fsm_state = state;
    assign rd_addr   = idx_n;

    obs_frame_buf #(.DEPTH(N - 1), .W(SW), .AW(LW)) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (cnt),
        .wdata (s_sym),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bad_n    = bad;
        idx_n    = idx;
        length_n = length;
        err_n    = 1'b0;
        trunc_n  = 1'b0;
        we       = 1'b0;
        case (state)
            ST_CAPTURE: begin
                if (accept) begin
                    we    = 1'b1;
                    cnt_n = cnt + LW'(1);
                    bad_n = bad | sym_bad;
                    // Frame closes on s_last or when the buffer holds N-1 symbols.
                    if (s_last || cnt == LAST_CNT) begin
                        trunc_n = !s_last;
                        if (bad_n) begin
                            err_n = 1'b1;
                            cnt_n = '0;
                            bad_n = 1'b0;
                        end else begin
                            length_n = cnt + LW'(1);
                            idx_n    = '0;
                            state_n  = ST_PLAY_V;
                        end
                    end
                end
            end
            ST_PLAY_V: begin
                state_n = (idx + LW'(1) == length) ? ST_WAIT_DONE : ST_PLAY_G;
            end
            ST_PLAY_G: begin
                idx_n   = idx + LW'(1);
                state_n = ST_PLAY_V;
            end
            ST_WAIT_DONE: begin
                if (dec_done) begin
                    cnt_n   = '0;
                    state_n = ST_CAPTURE;
                end
            end
            default: state_n = ST_CAPTURE;
        endcase
    end

    // The first symbol of a one-beat frame is written on the same edge it is registered out.
    always_comb begin
        play_n = (state_n == ST_PLAY_V);
        sym_n  = '0;
        if (play_n) begin
            sym_n = (we && cnt == idx_n) ? s_sym : rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CAPTURE;
            cnt         <= '0;
            bad         <= 1'b0;
            idx         <= '0;
            length      <= '0;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            start       <= 1'b0;
            obs_valid   <= 1'b0;
            obs_in      <= '0;
            frame_err   <= 1'b0;
            frame_trunc <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bad         <= bad_n;
            idx         <= idx_n;
            length      <= length_n;
            s_ready     <= (state_n == ST_CAPTURE);
            busy        <= (state_n != ST_CAPTURE);
            start       <= play_n && (idx_n == '0);
            obs_valid   <= play_n;
            obs_in      <= sym_n;
            frame_err   <= err_n;
            frame_trunc <= trunc_n;
        end
    end

`ifdef VITERBI_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_sent    <= '0;
            frames_dropped <= '0;
        end else begin
            if (play_n && idx_n == '0 && frames_sent != '1) begin
                frames_sent <= frames_sent + STAT_W'(1);
            end
            if (err_n && frames_dropped != '1) begin
                frames_dropped <= frames_dropped + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/viterbi_obs_feeder.md
# viterbi_obs_feeder

Upstream framing stage for `viterbi_top`. Accepts a valid/ready stream of observation symbols with an end-of-frame marker and buffers one frame of up to N-1 symbols. It then drives the decoder's `start`/`length`/`obs_in`/`obs_valid` pins with the fixed one-symbol-every-two-cycles cadence the decoder consumes. It holds off further input until the decoder reports `done`.

## Interface
Parameters:
- `N`, 8: decoder sequence length; max frame = N-1 symbols (`length` is `$clog2(N)` bits).
- `K`, 3: number of observation symbols; legal symbol values are 0..K-1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_sym`  in  `$clog2(K)`  incoming observation symbol.
- `s_valid`  in  1  `s_sym` and `s_last` are valid.
- `s_last`  in  1  final symbol of the frame.
- `s_ready`  out  1  beat accepted when `s_valid & s_ready`.
- `start`  out  1  one-cycle decoder start pulse.
- `length`  out  `$clog2(N)`  frame length, held stable from `start` until `done`.
- `obs_in`  out  `$clog2(K)`  symbol to the decoder.
- `obs_valid`  out  1  `obs_in` valid.
- `dec_done`  in  1  decoder `done`.
- `busy`  out  1  frame being played or awaiting `dec_done`.
- `frame_err`  out  1  one-cycle pulse: frame dropped for an illegal symbol.
- `frame_trunc`  out  1  one-cycle pulse: frame cut at N-1 symbols.

## Operation
- FSM states: CAPTURE → PLAY_V → PLAY_G → WAIT_DONE → CAPTURE.
- **CAPTURE**
  - `s_ready`=1. Each accepted beat writes `buf[cnt]` and increments `cnt`.
  - Any accepted `s_sym` ≥ K sets a sticky `bad` flag.
  - Frame end happens on the earlier of an accepted beat with `s_last`=1, or the accepted beat that makes `cnt`=N-1.
  - At frame end with `bad`: pulse `frame_err`, clear `cnt` and `bad`, stay in CAPTURE.
  - At frame end otherwise: latch `length`=`cnt`, set `idx`=0, go to PLAY_V.
  - If the N-1-th beat has `s_last`=0: pulse `frame_trunc`. Later beats start a new frame.
- **PLAY_V**
  - `obs_valid`=1, `obs_in`=`buf[idx]`, `start`=(`idx`==0).
  - If `idx`==`length`-1, go to WAIT_DONE; else go to PLAY_G.
- **PLAY_G**
  - `obs_valid`=0, `idx`++, go to PLAY_V.
- **WAIT_DONE**
  - `dec_done` sampled high → clear `cnt`, go to CAPTURE.
- `dec_done` is ignored outside WAIT_DONE.
- `s_ready`=0 in every state except CAPTURE.
- `busy`=1 in PLAY_V, PLAY_G and WAIT_DONE.

## Timing
- Reset values:
  - `s_ready`=1, `start`=0, `length`=0, `obs_in`=0, `obs_valid`=0, `busy`=0, `frame_err`=0, `frame_trunc`=0.
  - `cnt`=0, `bad`=0, FSM=CAPTURE.
- All outputs are registered.
- Frame-end beat accepted at edge E:
  - `start` and `obs_valid` for symbol 0 are high in cycle E+1.
  - Symbol k is presented in cycle E+1+2k.
  - WAIT_DONE is entered in cycle E+2L.
- Length 1: a single `start`/`obs_valid` cycle, then WAIT_DONE.
- `dec_done` high at edge D: `s_ready`=1 in cycle D+1; the next beat can be accepted at that edge.
- `frame_err` and `frame_trunc` are high in the cycle after the frame-end beat.
- Reset asserted mid-PLAY or mid-WAIT_DONE:
  - Next cycle all outputs are at reset values and the buffered frame is discarded.
  - The decoder shares `rst`.

## Configuration
- `VITERBI_FEEDER_STATS_EN` defined: adds outputs `frames_sent[15:0]` and `frames_dropped[15:0]`.
  - `frames_sent` increments on each `start`.
  - `frames_dropped` increments on each `frame_err`.
  - Both saturate at 0xFFFF and reset to 0.
- Macro undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- `viterbi_pkg` holds:
  - the FSM state enum;
  - width localparams derived from N and K (symbol, length and index widths);
  - the stats counter width.
- The same package is shared with `viterbi_top`.
- One sub-module, `obs_frame_buf`: N-1 × `$clog2(K)` register array with a write port (`we`, `waddr`, `wdata`) and a combinational read port (`raddr`).
- The FSM, counters and flags stay in the top of this block.

## Test plan
- Frame 0,0,1,1,2 (last on 5th beat), N=8 → `length`=5.
  - `start`+`obs_valid` with `obs_in`=0 one cycle after the last beat.
  - Then `obs_valid` pulses carrying 0,1,1,2 every 2nd cycle.
  - `s_ready`=0 until `dec_done`.
- 9 beats with no `s_last` (N=8):
  - Frame of 7 symbols played with `length`=7 and `frame_trunc` pulsed.
  - Beats 8–9 form the next frame after `dec_done`.
- Frame 0,3,1 with K=3 → `frame_err` pulse, no `start`, `s_ready` stays 1. With `VITERBI_FEEDER_STATS_EN`, `frames_dropped`=1.
- Single-symbol frame (2, last) → one cycle with `start`=1, `obs_valid`=1, `obs_in`=2, `length`=1, then WAIT_DONE.
- `dec_done` pulsed during PLAY_G of a length-4 frame → ignored; all 4 symbols are still presented.
- `rst` raised during the third symbol's PLAY_V → next cycle all outputs are at reset values and `s_ready`=1; a fresh frame then plays from symbol 0.
